sha_256_pad: RTL and testbench
==============================

Name: sha_256_pad

Overview:
- Message front-end for the sha_256 core: accepts a byte-granular message as a stream of 32-bit big-endian words.
- Applies FIPS 180-4 padding: a 0x80 byte, then zeros, then the 64-bit bit length.
- Drives the core's block interface (Data, Index, Operation, Enable) one 512-bit block at a time and waits for the core's Ready.
- Sits directly in front of sha_256; the digest is read from the core's Hash when Done pulses.

Parameters:
- LEN_W, 64, width of the message bit-length counter; the upper bits of the length field are zero-extended when LEN_W < 64.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- Mode  in  2  0 = SHA-224, 1 = SHA-256; sampled on the first accepted word of a message
- S_Data  in  32  message word; byte 0 is S_Data[31:24]
- S_Bytes  in  3  valid bytes in S_Data, 1..4; 0 is legal only with S_Last (empty tail word)
- S_Last  in  1  final word of the message
- S_Valid  in  1  word valid
- S_Ready  out  1  word accepted when S_Valid and S_Ready are both high
- Data  out  512  block to core; word i at Data[i*32 +: 32]; word 0 is the first message word
- Index  out  64  block number to core; 1 for the first block of a message
- Operation  out  2  to core; holds the sampled Mode
- Enable  out  1  one-cycle start pulse to core
- Ready  in  1  core block-done strobe
- Done  out  1  one-cycle pulse; core Hash valid from this cycle until the next Enable

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, block word counter 0, byte counter 0, Data=0, Index=0, Operation=0, Enable=0, Done=0, S_Ready=0 in the reset cycle and 1 from the next cycle.
- Reset mid-operation aborts the message with the same values. The core must share rst.

States:
- IDLE: S_Ready=1. The first accepted word samples Mode, sets Index=1 and clears the byte counter, then the word is handled as in FILL.
- FILL: S_Ready=1, one word per cycle.
  - A non-last word is written to word slot w; w increments and the byte counter adds 4.
  - At w==16 the block is full: go to SEND.
- SEND: Enable=1 for exactly one cycle, then WAIT. S_Ready=0.
- WAIT: S_Ready=0; Data, Index and Operation are held stable until Ready=1.
  - On Ready: if a pending block exists, Index+=1, Data=pending, go to SEND.
  - Else if the message is complete, Done=1 next cycle, go to IDLE.
  - Otherwise Index+=1, clear Data, w=0, go to FILL.
- Last word (S_Last), with b = S_Bytes and byte offset o = 4w+b within the block:
  - Keep bytes 0..b-1 of the word and zero the rest.
  - Write 0x80 at block byte o; when o==64, it goes into byte 0 of a pending block.
  - The byte counter adds b.
  - If o ≤ 55: words 14..15 = {bitlen} (big-endian 64-bit, word14 = high), then SEND.
  - Else: the current block is sent as-is, and the pending block is zeros plus the length in words 14..15 (plus 0x80 in word 0 when o==64).
- bitlen = bytecount·8, computed modulo 2^LEN_W.
- An empty message (S_Last, S_Bytes=0, w=0) produces one block: word0 = 0x80000000, rest 0.
- S_Valid while S_Ready=0 is ignored; the source holds the word.
- Enable never asserts except in SEND; Ready outside WAIT is ignored.

Decomposition:
- Package sha_const: state encoding localparams IDLE/FILL/SEND/WAIT and the mode constants SHA224=0, SHA256=1.
- Registers use the codebase's packed reg_type record with the comb/ff split.
- No sub-module. The byte-mask/0x80 insertion is a local function.

Test Plan:
1. "abc" (one word, S_Bytes=3, S_Last), Mode=1 -> one block: word0=0x61626380, words 1..14=0, word15=0x00000018, Index=1. After Done, core Hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
2. Empty message (S_Bytes=0, S_Last), Mode=1 -> word0=0x80000000, word15=0. Hash = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
3. 56-byte "abcdbcdecdef...nopq", Mode=1 -> two blocks, Index 1 then 2.
   - Block 1: word14=0x80000000, word15=0.
   - Block 2: words 0..13=0, word15=0x000001C0.
   - Hash = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
4. 64-byte message (last word S_Bytes=4 at w=15) -> block 2: word0=0x80000000, word15=0x00000200. Exactly two Enable pulses and one Done.
5. "abc" with Mode=0 -> Operation=0 held through the message. Hash[255:32] = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7.
6. Assert rst=0 in WAIT while S_Valid is held high -> next cycle Enable=0, Done=0, Index=0. A subsequent "abc" yields the test 1 digest.

Source files
------------

// File: rtl/sha_256_pad_pkg.sv
// Shared constants for the sha_256 message front-end: FSM encoding and hash mode values.
package sha_const;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  localparam logic [1:0] SHA224 = 2'd0;
  localparam logic [1:0] SHA256 = 2'd1;

endpackage

// File: rtl/sha_256_pad.sv
// FIPS 180-4 padding front-end: packs a byte-granular word stream into 512-bit blocks,
// appends 0x80 and the 64-bit bit length, and hands each block to the sha_256 core.
module sha_256_pad
  import sha_const::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   Mode,
  input  logic [31:0]  S_Data,
  input  logic [2:0]   S_Bytes,
  input  logic         S_Last,
  input  logic         S_Valid,
  output logic         S_Ready,
  output logic [511:0] Data,
  output logic [63:0]  Index,
  output logic [1:0]   Operation,
  output logic         Enable,
  input  logic         Ready,
  output logic         Done
);

  typedef struct packed {
    logic [1:0]       state;
    logic [4:0]       w;
    logic [LEN_W-1:0] bcnt;
    logic [511:0]     data;
    logic [511:0]     pend;
    logic             pend_vld;
    logic             last;
    logic [63:0]      index;
    logic [1:0]       op;
    logic             done;
  } reg_type;

  reg_type r, rin;

  // Keep the first nb bytes, place 0x80 right after them, zero the remainder.
  function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [2:0] nb);
    logic [31:0] w;
    w = d;
    for (int k = 0; k < 4; k++) begin
      if (k == int'(nb)) begin
        w[31-8*k -: 8] = 8'h80;
      end else if (k > int'(nb)) begin
        w[31-8*k -: 8] = 8'h00;
      end
    end
    return w;
  endfunction

  logic             accept;
  logic [4:0]       wv;
  logic [2:0]       nb;
  logic [6:0]       off;
  logic [LEN_W-1:0] bcnt_v;
  logic [LEN_W-1:0] bitlen;
  logic [63:0]      len64;
  logic [511:0]     data_v;
  logic [511:0]     pend_v;

  always_comb begin
    rin    = r;
    rin.done = 1'b0;
    accept = S_Valid && S_Ready;
    wv     = r.w;
    bcnt_v = r.bcnt;
    data_v = r.data;
    pend_v = '0;
    nb     = 3'd4;
    off    = '0;
    bitlen = '0;
    len64  = '0;

    case (r.state)
      IDLE, FILL: begin
        if (accept) begin
          if (r.state == IDLE) begin
            rin.op    = Mode;
            rin.index = 64'd1;
            wv        = '0;
            bcnt_v    = '0;
            data_v    = '0;
          end
          if (!S_Last) begin
            data_v[32*wv +: 32] = S_Data;
            rin.w     = wv + 5'd1;
            rin.bcnt  = bcnt_v + LEN_W'(4);
            rin.last  = 1'b0;
            rin.state = (wv == 5'd15) ? SEND : FILL;
          end else begin
            nb       = (S_Bytes > 3'd4) ? 3'd4 : S_Bytes;
            off      = {wv, 2'b00} + {4'd0, nb};
            rin.bcnt = bcnt_v + LEN_W'(nb);
            bitlen   = rin.bcnt << 3;
            len64    = 64'(bitlen);
            data_v[32*wv +: 32] = pad_word(S_Data, nb);
            // A full tail word pushes the 0x80 marker into the next word, or the next block.
            if (nb == 3'd4) begin
              if (wv == 5'd15) begin
                pend_v[31:0] = 32'h8000_0000;
              end else begin
                data_v[32*(wv+5'd1) +: 32] = 32'h8000_0000;
              end
            end
            if (off <= 7'd55) begin
              data_v[479:448] = len64[63:32];
              data_v[511:480] = len64[31:0];
              rin.pend_vld    = 1'b0;
            end else begin
              pend_v[479:448] = len64[63:32];
              pend_v[511:480] = len64[31:0];
              rin.pend_vld    = 1'b1;
            end
            rin.pend  = pend_v;
            rin.last  = 1'b1;
            rin.w     = wv;
            rin.state = SEND;
          end
          rin.data = data_v;
        end
      end
      SEND: begin
        rin.state = WAIT;
      end
      default: begin
        if (Ready) begin
          if (r.pend_vld) begin
            rin.index    = r.index + 64'd1;
            rin.data     = r.pend;
            rin.pend_vld = 1'b0;
            rin.state    = SEND;
          end else if (r.last) begin
            rin.done  = 1'b1;
            rin.last  = 1'b0;
            rin.state = IDLE;
          end else begin
            rin.index = r.index + 64'd1;
            rin.data  = '0;
            rin.w     = '0;
            rin.state = FILL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r <= '0;
    end else begin
      r <= rin;
    end
  end

  assign S_Ready   = rst && ((r.state == IDLE) || (r.state == FILL));
  assign Enable    = rst && (r.state == SEND);
  assign Data      = r.data;
  assign Index     = r.index;
  assign Operation = r.op;
  assign Done      = r.done;

endmodule

// File: tb/tb_sha_256_pad.sv
// Randomized bench for sha_256_pad: a byte-queue padding model predicts every block,
// and a small core stand-in answers Enable with a delayed Ready.
module tb_sha_256_pad;
  import sha_const::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   Mode = '0;
  logic [31:0]  S_Data = '0;
  logic [2:0]   S_Bytes = '0;
  logic         S_Last = 1'b0;
  logic         S_Valid = 1'b0;
  logic         S_Ready;
  logic [511:0] Data;
  logic [63:0]  Index;
  logic [1:0]   Operation;
  logic         Enable;
  logic         Ready = 1'b0;
  logic         Done;

  always #5 clk = ~clk;

  sha_256_pad #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .Mode      (Mode),
    .S_Data    (S_Data),
    .S_Bytes   (S_Bytes),
    .S_Last    (S_Last),
    .S_Valid   (S_Valid),
    .S_Ready   (S_Ready),
    .Data      (Data),
    .Index     (Index),
    .Operation (Operation),
    .Enable    (Enable),
    .Ready     (Ready),
    .Done      (Done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected blocks of the message in flight, filled by the driver, consumed by the core model.
  logic [511:0] exp_q[$];
  logic [1:0]   exp_op = '0;
  byte unsigned msg[$];

  int           en_cnt = 0;
  int           done_cnt = 0;
  int           blk_no = 0;
  bit           outstanding = 1'b0;
  int           ready_dly = 0;
  logic [511:0] held_blk = '0;
  logic [511:0] cur;

  always @(negedge clk) begin
    if (!rst) begin
      outstanding = 1'b0;
      Ready       = 1'b0;
      blk_no      = 0;
    end else begin
      Ready = 1'b0;
      if (Done) begin
        done_cnt++;
        check_eq("blocks_left_at_done", 512'(exp_q.size()), 512'd0);
        blk_no = 0;
      end
      if (Enable) begin
        en_cnt++;
        blk_no++;
        check_eq("enable_while_busy", 512'(outstanding), 512'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_enable", 512'd1, 512'(exp_q.size()));
        end else begin
          cur = exp_q.pop_front();
          check_eq("block_data", Data, cur);
          check_eq("block_index", 512'(Index), 512'(blk_no));
          check_eq("operation", 512'(Operation), 512'(exp_op));
        end
        held_blk    = Data;
        outstanding = 1'b1;
        ready_dly   = int'($urandom_range(0, 5));
      end else if (outstanding) begin
        check_eq("data_hold", Data, held_blk);
        check_eq("op_hold", 512'(Operation), 512'(exp_op));
        if (ready_dly == 0) begin
          Ready       = 1'b1;
          outstanding = 1'b0;
        end else begin
          ready_dly--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        Ready = 1'b1;  // stray strobe outside WAIT must be ignored
      end
    end
  end

  task automatic build_expected(input logic [1:0] mode);
    byte unsigned p[$];
    logic [63:0]  bits;
    logic [511:0] b;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    exp_q.delete();
    for (int blk = 0; blk < p.size() / 64; blk++) begin
      b = '0;
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 4; j++) b[i*32 + 31 - 8*j -: 8] = p[64*blk + 4*i + j];
      end
      exp_q.push_back(b);
    end
    exp_op = mode;
  endtask

  task automatic drive_msg(input logic [1:0] mode, input bit tail_empty, input bit wait_done);
    int len, nw, i, t, nblk, en_base, done_base, nb;
    logic [31:0] d;
    len = msg.size();
    build_expected(mode);
    nblk = exp_q.size();
    en_base = en_cnt;
    done_base = done_cnt;
    if (len == 0) nw = 1;
    else nw = (len + 3) / 4 + ((tail_empty && (len % 4 == 0)) ? 1 : 0);
    i = 0;
    t = 0;
    while (i < nw && t < 5000) begin
      @(negedge clk);
      t++;
      if ($urandom_range(0, 3) == 0) begin
        S_Valid = 1'b0;
        S_Data  = $urandom;
      end else begin
        d  = $urandom;
        nb = (i == nw - 1) ? len - 4 * i : 4;
        for (int j = 0; j < nb; j++) d[31 - 8*j -: 8] = msg[4*i + j];
        S_Data  = d;
        S_Bytes = 3'(nb);
        S_Last  = (i == nw - 1);
        Mode    = (i == 0) ? mode : 2'($urandom);
        S_Valid = 1'b1;
        if (S_Ready) i++;
      end
    end
    check_eq("words_accepted", 512'(i), 512'(nw));
    if (!wait_done) return;
    @(negedge clk);
    S_Valid = 1'b0;
    S_Last  = 1'b0;
    t = 0;
    while (done_cnt == done_base && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check_eq("done_count", 512'(done_cnt - done_base), 512'd1);
    check_eq("enable_count", 512'(en_cnt - en_base), 512'(nblk));
  endtask

  task automatic set_str(input string s);
    msg.delete();
    for (int k = 0; k < s.len(); k++) msg.push_back(s[k]);
  endtask

  task automatic set_rand(input int len);
    msg.delete();
    for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", 512'(S_Ready), 512'd0);
    check_eq("rst_enable", 512'(Enable), 512'd0);
    check_eq("rst_done", 512'(Done), 512'd0);
    check_eq("rst_index", 512'(Index), 512'd0);
    check_eq("rst_data", Data, 512'd0);
    check_eq("rst_operation", 512'(Operation), 512'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("s_ready_after_rst", 512'(S_Ready), 512'd1);

    set_str("abc");
    drive_msg(SHA256, 1'b0, 1'b1);
    msg.delete();
    drive_msg(SHA256, 1'b0, 1'b1);
    set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    drive_msg(SHA256, 1'b0, 1'b1);
    set_rand(64);
    drive_msg(SHA256, 1'b0, 1'b1);
    set_rand(64);
    drive_msg(SHA256, 1'b1, 1'b1);
    set_str("abc");
    drive_msg(SHA224, 1'b0, 1'b1);

    // Abort in WAIT with the source still presenting a word.
    set_str("abc");
    drive_msg(SHA256, 1'b0, 1'b0);
    t = 0;
    while (!outstanding && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("reached_wait", 512'(outstanding), 512'd1);
    S_Valid = 1'b1;
    S_Data  = 32'h1234_5678;
    S_Bytes = 3'd4;
    S_Last  = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    check_eq("abort_enable", 512'(Enable), 512'd0);
    check_eq("abort_done", 512'(Done), 512'd0);
    check_eq("abort_index", 512'(Index), 512'd0);
    check_eq("abort_data", Data, 512'd0);
    check_eq("abort_s_ready", 512'(S_Ready), 512'd0);
    @(negedge clk);
    S_Valid = 1'b0;
    rst     = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("abort_recover_s_ready", 512'(S_Ready), 512'd1);
    set_str("abc");
    drive_msg(SHA256, 1'b0, 1'b1);

    for (int n = 0; n < 25; n++) begin
      set_rand(int'($urandom_range(0, 150)));
      drive_msg(2'($urandom_range(0, 1)), 1'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
